// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package: hazard-controller FSM states and the default memory timeout.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } hc_state_e;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/hazard_ctrl_wait_timer.sv
// Memory-wait cycle counter. Saturates at MEM_TIMEOUT-1 and flags the last cycle
// before the timeout so the controller can fault on that same edge.
module hazard_ctrl_wait_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_last
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] PRE  = CW'(MEM_TIMEOUT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt_q <= '0;
    end else if (inc && cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The increment on this cycle would reach MEM_TIMEOUT-1.
  assign at_last = (cnt_q == PRE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory wait with
// timeout, and HALT. Optional stall counter enabled by `define HAZARD_CTRL_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       rs_id,
  input  logic [2:0]       rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic [2:0]       regwrite_adr_ex,
  input  logic             regwrite_ex,
  input  logic             load_ex,
  input  logic             branch_taken_ex,
  input  logic             halt_id,
  input  logic             mem_req_ex,
  input  logic             mem_ready,
  input  logic             restart,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             mem_err
);

  hc_state_e state_q, state_d;
  logic      load_use;
  logic      timer_clear, timer_inc, timer_last;
  logic      err_set, err_clr;

  assign load_use = load_ex && regwrite_ex &&
                    ((uses_rs_id && rs_id == regwrite_adr_ex) ||
                     (uses_rt_id && rt_id == regwrite_adr_ex));

  hazard_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .at_last (timer_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_clr)      mem_err <= 1'b0;
      else if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    timer_clear = 1'b1;
    timer_inc   = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken branch outranks the hazard and halt: the ID instruction is wrong-path.
        if (mem_req_ex && !mem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          state_d = ST_MEMWAIT;
        end else if (branch_taken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          {pc_en, ifid_en} = 2'b00;
          idex_flush = 1'b1;
        end else if (halt_id) begin
          {pc_en, ifid_en} = 2'b00;
          idex_flush = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          timer_clear = 1'b0;
          timer_inc   = 1'b1;
          if (timer_last) begin
            err_set = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        if (restart) begin
          err_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (!reset) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign halted = reset && (state_q == ST_HALT);

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a behavioural model. Honours HAZARD_CTRL_PERF_EN.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic [2:0] wadr;
    logic       rw;
    logic       ld;
    logic       br;
    logic       hlt;
    logic       req;
    logic       rdy;
    logic       rstrt;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rs_id, rt_id, regwrite_adr_ex;
  logic       uses_rs_id, uses_rt_id, regwrite_ex, load_ex, branch_taken_ex;
  logic       halt_id, mem_req_ex, mem_ready, restart;
  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, halted, mem_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  last_out;
  logic [31:0] last_stall;
  logic [31:0] last_stall4;

  // behavioural model state
  bit m_wait, m_halt, m_err;
  int m_low, m_stall;

  always #5 clk = ~clk;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [3:0]       stall_cnt4;
  logic p4, f4, x4, e4, iff4, idf4, h4, me4;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .regwrite_adr_ex(regwrite_adr_ex), .regwrite_ex(regwrite_ex), .load_ex(load_ex),
    .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .mem_req_ex(mem_req_ex),
    .mem_ready(mem_ready), .restart(restart), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_err(mem_err)
  );

`ifdef HAZARD_CTRL_PERF_EN
  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .regwrite_adr_ex(regwrite_adr_ex), .regwrite_ex(regwrite_ex), .load_ex(load_ex),
    .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .mem_req_ex(mem_req_ex),
    .mem_ready(mem_ready), .restart(restart), .pc_en(p4), .ifid_en(f4),
    .idex_en(x4), .exmem_en(e4), .ifid_flush(iff4), .idex_flush(idf4), .halted(h4),
    .stall_cnt(stall_cnt4), .mem_err(me4)
  );
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic in_t rstv();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t lu_rs();
    in_t v;
    v = idle();
    v.ld = 1'b1; v.rw = 1'b1; v.wadr = 3'd3; v.rs = 3'd3; v.urs = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input in_t i, input logic [7:0] e, input string n);
    vec_t r;
    r.in = i; r.exp = e; r.name = n;
    return r;
  endfunction

  // Apply one cycle of inputs, sample at the falling edge, compare to the model.
  task automatic step(input in_t v);
    logic [6:0] e;
    logic [7:0] req;
    bit lu;
    reset = v.rst_n; rs_id = v.rs; rt_id = v.rt; uses_rs_id = v.urs; uses_rt_id = v.urt;
    regwrite_adr_ex = v.wadr; regwrite_ex = v.rw; load_ex = v.ld; branch_taken_ex = v.br;
    halt_id = v.hlt; mem_req_ex = v.req; mem_ready = v.rdy; restart = v.rstrt;
    @(negedge clk);
    last_out = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, halted, mem_err};
`ifdef HAZARD_CTRL_PERF_EN
    last_stall  = 32'(stall_cnt);
    last_stall4 = 32'(stall_cnt4);
`else
    last_stall  = 32'd0;
    last_stall4 = 32'd0;
`endif
    lu = v.ld && v.rw && ((v.urs && v.rs == v.wadr) || (v.urt && v.rt == v.wadr));
    if (!v.rst_n)                e = 7'b1111_11_0;
    else if (m_halt)             e = 7'b0000_00_1;
    else if (m_wait)             e = v.rdy ? 7'b1111_00_0 : 7'b0000_00_0;
    else if (v.req && !v.rdy)    e = 7'b0000_00_0;
    else if (v.br)               e = 7'b1111_11_0;
    else if (lu || v.hlt)        e = 7'b0011_01_0;
    else                         e = 7'b1111_00_0;
    req = {e, m_err};
    check("model_outputs", 32'(last_out), 32'(req));
`ifdef HAZARD_CTRL_PERF_EN
    check("model_stall_cnt", last_stall, 32'(m_stall));
`endif
    if (!v.rst_n) begin
      m_wait = 0; m_halt = 0; m_err = 0; m_low = 0; m_stall = 0;
    end else begin
      if (!e[6] && m_stall < STALL_MAX) m_stall++;
      if (m_halt) begin
        if (v.rstrt) begin m_halt = 0; m_err = 0; end
      end else if (m_wait) begin
        if (v.rdy) m_wait = 0;
        else begin
          m_low++;
          if (m_low == MEM_TIMEOUT) begin m_wait = 0; m_halt = 1; m_err = 1; end
        end
      end else if (v.req && !v.rdy) begin
        m_wait = 1; m_low = 1;
      end else if (!v.br && !lu && v.hlt) begin
        m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[$];
    in_t  v;

    // Initial unchecked reset so no register is X when comparisons start.
    v = rstv();
    reset = 1'b0; rs_id = '0; rt_id = '0; uses_rs_id = 0; uses_rt_id = 0;
    regwrite_adr_ex = '0; regwrite_ex = 0; load_ex = 0; branch_taken_ex = 0;
    halt_id = 0; mem_req_ex = 0; mem_ready = 0; restart = 0;
    m_wait = 0; m_halt = 0; m_err = 0; m_low = 0; m_stall = 0;
    @(posedge clk); #1;

    // Vector table: each entry applied for one cycle from RUN right after reset.
    vecs.push_back(mk(idle(), 8'b1111_00_00, "idle"));
    vecs.push_back(mk(lu_rs(), 8'b0011_01_00, "load_use_rs"));
    v = idle(); v.ld = 1; v.rw = 1; v.wadr = 3'd5; v.rt = 3'd5; v.urt = 1;
    vecs.push_back(mk(v, 8'b0011_01_00, "load_use_rt"));
    v = lu_rs(); v.urs = 0;
    vecs.push_back(mk(v, 8'b1111_00_00, "no_use_no_hazard"));
    v = lu_rs(); v.rw = 0;
    vecs.push_back(mk(v, 8'b1111_00_00, "load_no_regwrite"));
    v = lu_rs(); v.br = 1;
    vecs.push_back(mk(v, 8'b1111_11_00, "branch_over_hazard"));
    v = idle(); v.hlt = 1;
    vecs.push_back(mk(v, 8'b0011_01_00, "halt_id"));
    v = idle(); v.hlt = 1; v.br = 1;
    vecs.push_back(mk(v, 8'b1111_11_00, "branch_over_halt"));
    v = lu_rs(); v.br = 1; v.req = 1;
    vecs.push_back(mk(v, 8'b0000_00_00, "memwait_over_all"));
    v = idle(); v.req = 1; v.rdy = 1;
    vecs.push_back(mk(v, 8'b1111_00_00, "mem_ready_same_cycle"));
    v = idle(); v.rdy = 1; v.rstrt = 1;
    vecs.push_back(mk(v, 8'b1111_00_00, "ready_restart_in_run"));
    vecs.push_back(mk(rstv(), 8'b1111_11_00, "in_reset"));
    foreach (vecs[i]) begin
      step(rstv());
      step(vecs[i].in);
      check(vecs[i].name, 32'(last_out), 32'(vecs[i].exp));
    end

    // Load-use stalls exactly one cycle.
    step(rstv());
    step(lu_rs());
    check("lu_stall", 32'(last_out[7:6]), 32'b00);
    step(idle());
    check("lu_one_cycle", 32'(last_out[7:6]), 32'b11);

    // Three wait cycles, released on the fourth.
    step(rstv());
    v = idle(); v.req = 1;
    for (int i = 0; i < 3; i++) begin
      step(v);
      check("memwait_en_low", 32'(last_out[7:4]), 32'h0);
    end
    v.rdy = 1;
    step(v);
    check("memwait_release", 32'(last_out[7:4]), 32'hF);
    step(idle());
    check("memwait_back_run", 32'(last_out), 32'b1111_00_00);

    // Timeout after 16 low cycles, then restart.
    step(rstv());
    v = idle(); v.req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step(v);
      check("timeout_pending", 32'(last_out[1:0]), 32'b00);
    end
    step(idle());
    check("timeout_halt_err", 32'(last_out[1:0]), 32'b11);
    v = idle(); v.rstrt = 1;
    step(v);
    check("restart_cycle_halted", 32'(last_out[1]), 32'b1);
    step(idle());
    check("restart_done", 32'({last_out[7], last_out[1:0]}), 32'b100);

    // Reset in the middle of a wait, then a full-length timeout.
    step(rstv());
    v = idle(); v.req = 1;
    for (int i = 0; i < 6; i++) step(v);
    step(rstv());
    step(idle());
    check("reset_midwait_run", 32'(last_out), 32'b1111_00_00);
`ifdef HAZARD_CTRL_PERF_EN
    check("reset_midwait_stall", last_stall, 32'd0);
`endif
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step(v);
      check("rewait_pending", 32'(last_out[1]), 32'b0);
    end
    step(idle());
    check("rewait_timeout", 32'(last_out[1:0]), 32'b11);

`ifdef HAZARD_CTRL_PERF_EN
    step(rstv());
    for (int i = 0; i < 10; i++) step(lu_rs());
    step(idle());
    check("perf_10_stalls", last_stall, 32'd10);
    for (int i = 0; i < 10; i++) step(lu_rs());
    step(idle());
    check("perf_sat_cnt_w4", last_stall4, 32'd15);
`endif

    // Randomized traffic against the model.
    step(rstv());
    for (int i = 0; i < 1500; i++) begin
      v.rst_n = ($urandom_range(0, 99) != 0);
      v.rs    = 3'($urandom_range(0, 3));
      v.rt    = 3'($urandom_range(0, 3));
      v.wadr  = 3'($urandom_range(0, 3));
      v.urs   = 1'($urandom_range(0, 1));
      v.urt   = 1'($urandom_range(0, 1));
      v.rw    = 1'($urandom_range(0, 1));
      v.ld    = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 5) == 0);
      v.hlt   = ($urandom_range(0, 19) == 0);
      v.req   = ($urandom_range(0, 3) == 0);
      v.rdy   = ($urandom_range(0, 4) == 0);
      v.rstrt = ($urandom_range(0, 2) == 0);
      step(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
